sram_axi_bridge: RTL and testbench

SRAM_AXI_BRIDGE -- requirements
Module: sram_axi_bridge

---
 rtl/mycpu_axi_pkg.sv | 29 ++
 rtl/sram_axi_bridge.sv | 188 ++++++++++++++++++
 tb/tb_sram_axi_bridge.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mycpu_axi_pkg.sv
// Shared types and helpers for the sram-like to AXI bridge.
// Holds FSM states, burst/size constants and the byte-strobe decode.
package mycpu_axi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    AR,
    R,
    AW_W,
    B
  } state_e;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] SIZE_WORD  = 2'b10;

  function automatic logic [3:0] wstrb_dec(
    input logic [1:0] size,
    input logic [1:0] off
  );
    logic [3:0] s;
    unique case (size)
      2'b00:   s = 4'b0001 << off;
      2'b01:   s = off[1] ? 4'b1100 : 4'b0011;
      default: s = 4'b1111;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/sram_axi_bridge.sv
// Two sram-like ports (inst, data) onto one AXI master, one
// transaction in flight; the data port wins simultaneous requests.
import mycpu_axi_pkg::*;

module sram_axi_bridge #(
  parameter logic [3:0] ID_INST = 4'd0,
  parameter logic [3:0] ID_DATA = 4'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic [31:0] inst_rdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_addr_ok,
  output logic        data_ok,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic        awvalid,
  input  logic        awready,
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  state_e      state_q, state_d;
  logic        wr_q, wr_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        src_q, src_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic [3:0]  id;
  logic [2:0]  axsize;

  // Response IDs and error codes carry nothing this bridge acts on.
  logic unused_resp;
  assign unused_resp = ^{rid, rresp, bid, bresp, wr_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      wr_q      <= 1'b0;
      size_q    <= 2'b00;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      src_q     <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_q      <= wr_d;
      size_q    <= size_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      src_q     <= src_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    wr_d         = wr_q;
    size_d       = size_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    src_d        = src_q;
    aw_done_d    = aw_done_q;
    w_done_d     = w_done_q;
    data_addr_ok = 1'b0;
    inst_addr_ok = 1'b0;
    data_ok      = 1'b0;
    inst_data_ok = 1'b0;
    arvalid      = 1'b0;
    rready       = 1'b0;
    awvalid      = 1'b0;
    wvalid       = 1'b0;
    bready       = 1'b0;
    if (!rst) begin
      unique case (state_q)
        IDLE: begin
          data_addr_ok = data_req;
          inst_addr_ok = inst_req & ~data_req;
          if (data_req | inst_req) begin
            src_d   = data_req;
            wr_d    = data_req ? data_wr    : inst_wr;
            size_d  = data_req ? data_size  : inst_size;
            addr_d  = data_req ? data_addr  : inst_addr;
            wdata_d = data_req ? data_wdata : inst_wdata;
            state_d = wr_d ? AW_W : AR;
          end
        end
        AR: begin
          arvalid = 1'b1;
          if (arready) state_d = R;
        end
        R: begin
          rready = 1'b1;
          if (rvalid & rlast) begin
            data_ok      = src_q;
            inst_data_ok = ~src_q;
            state_d      = IDLE;
          end
        end
        AW_W: begin
          awvalid   = ~aw_done_q;
          wvalid    = ~w_done_q;
          aw_done_d = aw_done_q | (awvalid & awready);
          w_done_d  = w_done_q | (wvalid & wready);
          if (aw_done_d & w_done_d) begin
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            state_d   = B;
          end
        end
        B: begin
          bready = 1'b1;
          if (bvalid) begin
            data_ok      = src_q;
            inst_data_ok = ~src_q;
            state_d      = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign id     = src_q ? ID_DATA : ID_INST;
  // Size 3 has no sram-like meaning; treat it as a full word.
  assign axsize = {1'b0, (size_q == 2'b11) ? SIZE_WORD : size_q};

  assign arid    = id;
  assign araddr  = addr_q;
  assign arlen   = 8'd0;
  assign arsize  = axsize;
  assign arburst = BURST_INCR;

  assign awid    = id;
  assign awaddr  = addr_q;
  assign awlen   = 8'd0;
  assign awsize  = axsize;
  assign awburst = BURST_INCR;

  assign wid   = id;
  assign wdata = wdata_q;
  assign wstrb = wstrb_dec(size_q, addr_q[1:0]);
  assign wlast = 1'b1;

  assign inst_rdata = rdata;
  assign data_rdata = rdata;

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Randomized bench for sram_axi_bridge with a tiny AXI slave driver.
// Expectations come from transaction-level rules, not RTL state.
module tb_sram_axi_bridge;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        inst_req, inst_wr;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr, inst_wdata, inst_rdata;
  logic        inst_addr_ok, inst_data_ok;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        data_addr_ok, data_ok;
  logic [3:0]  arid, rid, awid, wid, bid;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize;
  logic [1:0]  arburst, awburst, rresp, bresp;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready;
  logic [3:0]  wstrb;
  logic        bvalid, bready;

  int checks = 0;
  int errors = 0;

  sram_axi_bridge dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_wr(inst_wr),
    .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_wdata(inst_wdata), .inst_rdata(inst_rdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .data_req(data_req), .data_wr(data_wr),
    .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_rdata(data_rdata),
    .data_addr_ok(data_addr_ok), .data_ok(data_ok),
    .arid(arid), .araddr(araddr), .arlen(arlen),
    .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp),
    .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen),
    .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb),
    .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] m_size(input logic [1:0] sz);
    return (sz == 2'd3) ? 3'd2 : {1'b0, sz};
  endfunction

  // Bytes covered by an access, aligned down to its natural size.
  function automatic logic [3:0] m_strb(input logic [1:0] sz,
                                       input logic [31:0] a);
    int n;
    int off;
    n   = 1 << m_size(sz);
    off = int'(a[1:0]) & ~(n - 1);
    return 4'(((1 << n) - 1) << off);
  endfunction

  task automatic slave_idle();
    arready = 0; rvalid = 0; rlast = 0; rdata = 0;
    rid = 0; rresp = 0; awready = 0; wready = 0;
    bvalid = 0; bid = 0; bresp = 0;
  endtask

  task automatic clr_req();
    inst_req = 0; data_req = 0;
  endtask

  task automatic garbage_req();
    data_req = 1'($urandom); inst_req = 1'($urandom);
    data_wr = 1'($urandom); inst_wr = 1'($urandom);
    data_size = 2'($urandom); inst_size = 2'($urandom);
    data_addr = $urandom; inst_addr = $urandom;
    data_wdata = $urandom; inst_wdata = $urandom;
  endtask

  task automatic chk_ok(input bit dport, input bit fire);
    chk("data_ok", data_ok, dport & fire);
    chk("inst_ok", inst_data_ok, ~dport & fire);
  endtask

  task automatic txn(input bit dport, input bit wr,
                     input logic [1:0] sz, input logic [31:0] a,
                     input logic [31:0] wd, input int da,
                     input int db, input int dc, input bit both);
    logic [31:0] rv;
    logic [3:0] id;
    int n, cyc;
    bit aw_d, w_d, done;
    rv = $urandom;
    id = dport ? 4'd1 : 4'd0;
    cyc = 0;
    @(negedge clk);
    slave_idle();
    clr_req();
    if (dport) begin
      data_req = 1; data_wr = wr; data_size = sz;
      data_addr = a; data_wdata = wd;
      inst_req = both; inst_wr = 0; inst_addr = $urandom;
    end else begin
      inst_req = 1; inst_wr = wr; inst_size = sz;
      inst_addr = a; inst_wdata = wd;
    end
    #1;
    chk("addr_ok", {data_addr_ok, inst_addr_ok},
        dport ? 2'b10 : 2'b01);
    @(posedge clk); cyc++;
    @(negedge clk);
    garbage_req();
    if (!wr) begin
      n = 0; done = 0;
      while (!done) begin
        arready = (n >= da);
        #1;
        chk("busy_aok", {data_addr_ok, inst_addr_ok}, 0);
        chk("arvalid", arvalid, 1);
        chk("araddr", araddr, a);
        chk("arsize", arsize, m_size(sz));
        chk("arid", arid, id);
        chk("arlen", arlen, 0);
        chk("arburst", arburst, 1);
        done = arready;
        if (n > 64) begin chk("ar_timeout", 1, 0); done = 1; end
        @(posedge clk); cyc++; n++;
        @(negedge clk);
      end
      arready = 0;
      n = 0; done = 0;
      while (!done) begin
        rvalid = (n >= db); rlast = 1; rdata = rv;
        rid = id; rresp = 2'($urandom);
        #1;
        chk("arvalid_r", arvalid, 0);
        chk("rready", rready, 1);
        chk("busy_aok", {data_addr_ok, inst_addr_ok}, 0);
        chk_ok(dport, rvalid);
        if (rvalid) begin
          chk("rdata", dport ? data_rdata : inst_rdata, rv);
          if (da == 0 && db == 0) chk("rd_latency", cyc, 2);
          done = 1;
          clr_req();
        end
        if (n > 64) begin chk("r_timeout", 1, 0); done = 1; end
        @(posedge clk); cyc++; n++;
        @(negedge clk);
      end
    end else begin
      n = 0; aw_d = 0; w_d = 0;
      while (!(aw_d && w_d)) begin
        awready = (n >= da); wready = (n >= db);
        #1;
        chk("busy_aok", {data_addr_ok, inst_addr_ok}, 0);
        chk("awvalid", awvalid, !aw_d);
        chk("wvalid", wvalid, !w_d);
        chk("bready_aw", bready, 0);
        if (!aw_d) begin
          chk("awaddr", awaddr, a);
          chk("awsize", awsize, m_size(sz));
          chk("awid", awid, id);
          chk("awlen", awlen, 0);
          chk("awburst", awburst, 1);
        end
        if (!w_d) begin
          chk("wdata", wdata, wd);
          chk("wstrb", wstrb, m_strb(sz, a));
          chk("wlast", wlast, 1);
          chk("wid", wid, id);
        end
        chk_ok(dport, 0);
        if (awready) aw_d = 1;
        if (wready) w_d = 1;
        if (n > 64) begin
          chk("aw_timeout", 1, 0); aw_d = 1; w_d = 1;
        end
        @(posedge clk); n++;
        @(negedge clk);
      end
      awready = 0; wready = 0;
      n = 0; done = 0;
      while (!done) begin
        bvalid = (n >= dc); bid = id; bresp = 2'($urandom);
        #1;
        chk("awvalid_b", awvalid, 0);
        chk("wvalid_b", wvalid, 0);
        chk("bready", bready, 1);
        chk("busy_aok", {data_addr_ok, inst_addr_ok}, 0);
        chk_ok(dport, bvalid);
        if (bvalid) begin done = 1; clr_req(); end
        if (n > 64) begin chk("b_timeout", 1, 0); done = 1; end
        @(posedge clk); n++;
        @(negedge clk);
      end
    end
    slave_idle();
    clr_req();
  endtask

  task automatic reset_in_r();
    @(negedge clk);
    slave_idle(); clr_req();
    data_req = 1; data_wr = 0; data_size = 2;
    data_addr = $urandom;
    @(posedge clk);
    @(negedge clk);
    clr_req();
    arready = 1;
    @(posedge clk);
    @(negedge clk);
    arready = 0;
    #1;
    chk("pre_rst_rready", rready, 1);
    rst = 1; data_req = 1;
    #1;
    chk("rst_rready", rready, 0);
    chk("rst_aok", data_addr_ok, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 0; clr_req();
    #1;
    chk("post_rst_valids",
        {arvalid, rready, awvalid, wvalid, bready}, 0);
    chk_ok(1, 0);
  endtask

  initial begin
    slave_idle();
    clr_req();
    inst_wr = 0; inst_size = 0; inst_addr = 0; inst_wdata = 0;
    data_wr = 0; data_size = 0; data_addr = 0; data_wdata = 0;
    rst = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    data_req = 1; inst_req = 1;
    #1;
    chk("rst_valids", {arvalid, rready, awvalid, wvalid, bready}, 0);
    chk("rst_aok", {data_addr_ok, inst_addr_ok}, 0);
    chk("rst_dok", {data_ok, inst_data_ok}, 0);
    rst = 0;
    clr_req();
    @(posedge clk);

    txn(1, 0, 2, 32'h1FC0_0010, 0, 0, 0, 0, 0);
    txn(1, 0, 2, $urandom, 0, 0, 0, 0, 1);
    txn(0, 0, 2, $urandom, 0, 0, 0, 0, 0);
    txn(1, 1, 0, 32'h0000_0103, 32'h0000_00AB, 0, 0, 0, 0);
    txn(1, 1, 2, $urandom, $urandom, 3, 0, 1, 0);
    txn(0, 1, 1, 32'h0000_0002, $urandom, 0, 2, 0, 0);
    txn(1, 0, 1, $urandom, 0, 5, 0, 0, 0);
    txn(0, 1, 3, $urandom, $urandom, 1, 1, 2, 0);
    reset_in_r();
    txn(1, 0, 2, $urandom, 0, 0, 1, 0, 0);

    for (int i = 0; i < 60; i++) begin
      bit dp;
      dp = 1'($urandom);
      txn(dp, 1'($urandom), 2'($urandom), $urandom, $urandom,
          $urandom_range(0, 3), $urandom_range(0, 3),
          $urandom_range(0, 3), dp & 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
